// File: rtl/iopad_bank_pkg.sv
// rtl/iopad_bank_pkg.sv - shared constants and types for the IO pad bank
package iopad_bank_pkg;

  localparam int CFG_W        = 4;
  localparam int CFG_A2F_REG  = 0;
  localparam int CFG_A2F_SYNC = 1;
  localparam int CFG_F2A_REG  = 2;
  localparam int CFG_OE       = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/iopad_bank_if.sv
// rtl/iopad_bank_if.sv - serial configuration port of the IO pad bank
interface iopad_bank_cfg_if;

  logic cfg_valid;
  logic cfg_bit;
  logic cfg_ready;
  logic cfg_done;

  modport master (output cfg_valid, output cfg_bit, input cfg_ready, input cfg_done);
  modport slave  (input cfg_valid, input cfg_bit, output cfg_ready, output cfg_done);

endinterface

// File: rtl/iopad_bank_lane.sv
// rtl/iopad_bank_lane.sv - one pad: A2F/F2A flops, scan path and output muxes
module iopad_bank_lane
  import iopad_bank_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_scan_en,
  input  logic             i_sc_in,
  output logic             o_sc_out,
  input  logic [CFG_W-1:0] i_cfg,
  input  logic             i_pad_a2f,
  output logic             o_a2f,
  input  logic             i_f2a,
  output logic             o_pad_f2a,
  output logic             o_pad_oe
);

  logic r_a2f_ff0;
  logic r_a2f_ff1;
  logic r_f2a_ff;

  // Flops capture regardless of mode bits so a bypass->reg switch has no bubble.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a2f_ff0 <= 1'b0;
      r_a2f_ff1 <= 1'b0;
      r_f2a_ff  <= 1'b0;
    end else if (i_scan_en) begin
      r_a2f_ff0 <= i_sc_in;
      r_a2f_ff1 <= r_a2f_ff0;
      r_f2a_ff  <= r_a2f_ff1;
    end else begin
      r_a2f_ff0 <= i_pad_a2f;
      r_a2f_ff1 <= r_a2f_ff0;
      r_f2a_ff  <= i_f2a;
    end
  end

  always_comb begin
    o_a2f = i_pad_a2f;
    if (i_cfg[CFG_A2F_REG]) begin
      o_a2f = i_cfg[CFG_A2F_SYNC] ? r_a2f_ff1 : r_a2f_ff0;
    end
  end

  assign o_pad_f2a = i_cfg[CFG_F2A_REG] ? r_f2a_ff : i_f2a;
  assign o_pad_oe  = i_cfg[CFG_OE];
  assign o_sc_out  = r_f2a_ff;

endmodule

// File: rtl/logical_tile_io_mode_physical__iopad_bank.sv
// rtl/logical_tile_io_mode_physical__iopad_bank.sv - multi-pad IO tile with shadowed serial config
module logical_tile_io_mode_physical__iopad_bank
  import iopad_bank_pkg::*;
#(
  parameter int NUM_PADS = 4
) (
  input  logic                iopad_clk,
  input  logic                global_reset,
  input  logic                scan_en,
  input  logic                iopad_sc_in,
  output logic                iopad_sc_out,
  iopad_bank_cfg_if.slave     cfg,
  input  logic [NUM_PADS-1:0] gfpga_pad_a2f,
  output logic [NUM_PADS-1:0] gfpga_pad_f2a,
  output logic [NUM_PADS-1:0] gfpga_pad_oe,
  input  logic [NUM_PADS-1:0] iopad_f2a_i,
  output logic [NUM_PADS-1:0] iopad_a2f_o
);

  localparam int TOTAL = NUM_PADS * CFG_W;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL - 1);

  cfg_state_e       r_state;
  cfg_state_e       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [TOTAL-1:0] r_shadow;
  logic [TOTAL-1:0] r_active;
  logic             r_done;
  logic             w_ready;
  logic             w_accept;

  assign w_accept = cfg.cfg_valid & w_ready;

  always_ff @(posedge iopad_clk) begin
    if (global_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = (TOTAL == 1) ? COMMIT : LOAD;
      LOAD:    if (w_accept && (r_cnt == LAST_IDX)) w_next_state = COMMIT;
      COMMIT:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_ready = 1'b1;
    if (r_state == COMMIT) w_ready = 1'b0;
  end

  // Shadow fills bit by bit; active only ever changes as a whole in COMMIT.
  always_ff @(posedge iopad_clk) begin
    if (global_reset) begin
      r_cnt    <= '0;
      r_shadow <= '0;
      r_active <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == COMMIT);
      if (r_state == COMMIT) begin
        r_active <= r_shadow;
        r_cnt    <= '0;
      end else if (w_accept) begin
        for (int k = 0; k < TOTAL; k++) begin
          if (r_cnt == CNT_W'(k)) r_shadow[k] <= cfg.cfg_bit;
        end
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign cfg.cfg_ready = w_ready;
  assign cfg.cfg_done  = r_done;

  logic [NUM_PADS:0] w_chain;
  assign w_chain[0]   = iopad_sc_in;
  assign iopad_sc_out = w_chain[NUM_PADS];

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_lane
    iopad_bank_lane u_lane (
      .i_clk     (iopad_clk),
      .i_rst     (global_reset),
      .i_scan_en (scan_en),
      .i_sc_in   (w_chain[p]),
      .o_sc_out  (w_chain[p+1]),
      .i_cfg     (r_active[p*CFG_W +: CFG_W]),
      .i_pad_a2f (gfpga_pad_a2f[p]),
      .o_a2f     (iopad_a2f_o[p]),
      .i_f2a     (iopad_f2a_i[p]),
      .o_pad_f2a (gfpga_pad_f2a[p]),
      .o_pad_oe  (gfpga_pad_oe[p])
    );
  end

endmodule

// File: tb/tb_logical_tile_io_mode_physical__iopad_bank.sv
// tb/tb_logical_tile_io_mode_physical__iopad_bank.sv - scoreboard bench for the IO pad bank
module tb_logical_tile_io_mode_physical__iopad_bank;

  localparam int NUM_PADS = 4;
  localparam int TOTAL    = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                scan_en = 1'b0;
  logic                sc_in = 1'b0;
  logic                sc_out;
  logic [NUM_PADS-1:0] pad_a2f = '0;
  logic [NUM_PADS-1:0] f2a_i = '0;
  logic [NUM_PADS-1:0] pad_f2a;
  logic [NUM_PADS-1:0] pad_oe;
  logic [NUM_PADS-1:0] a2f_o;

  iopad_bank_cfg_if cfg_if ();

  logical_tile_io_mode_physical__iopad_bank #(.NUM_PADS(NUM_PADS)) dut (
    .iopad_clk     (clk),
    .global_reset  (rst),
    .scan_en       (scan_en),
    .iopad_sc_in   (sc_in),
    .iopad_sc_out  (sc_out),
    .cfg           (cfg_if),
    .gfpga_pad_a2f (pad_a2f),
    .gfpga_pad_f2a (pad_f2a),
    .gfpga_pad_oe  (pad_oe),
    .iopad_f2a_i   (f2a_i),
    .iopad_a2f_o   (a2f_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;
  int done_expected = 0;

  typedef struct packed {
    int         c;
    int         sel;
    logic [3:0] val;
    int         tag;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];

  localparam int S_A2F = 0, S_F2A = 1, S_OE = 2, S_SC = 3, S_RDY = 4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [3:0] observe(input int sel);
    case (sel)
      S_A2F:   return a2f_o;
      S_F2A:   return pad_f2a;
      S_OE:    return pad_oe;
      S_SC:    return {3'b000, sc_out};
      default: return {3'b000, cfg_if.cfg_ready};
    endcase
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      S_A2F:   return "a2f_o";
      S_F2A:   return "pad_f2a";
      S_OE:    return "pad_oe";
      S_SC:    return "sc_out";
      default: return "cfg_ready";
    endcase
  endfunction

  task automatic expect_at(input int c, input int sel, input logic [3:0] v, input int tag);
    exp_t e;
    e.c = c; e.sel = sel; e.val = v; e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Monitor: samples mid low-phase, after the stimulus of this negedge has settled.
  always @(negedge clk) begin
    int i;
    exp_t e;
    #2;
    i = 0;
    while (i < exp_q.size()) begin
      if (exp_q[i].c <= cyc) begin
        e = exp_q[i];
        exp_q.delete(i);
        check($sformatf("%s t%0d cyc%0d", sel_name(e.sel), e.tag, e.c), observe(e.sel), e.val);
      end else begin
        i++;
      end
    end
    while (done_q.size() > 0 && done_q[0] < cyc) begin
      report_fail($sformatf("cfg_done_missing cyc%0d", done_q.pop_front()));
    end
    if (cfg_if.cfg_done) begin
      done_seen++;
      if (done_q.size() > 0) check("cfg_done_cycle", cyc, done_q.pop_front());
      else report_fail($sformatf("cfg_done_unexpected cyc%0d", cyc));
    end
  end

  task automatic send_bit(input logic b, output int acc);
    int guard;
    guard = 0;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_bit   = b;
    while (cfg_if.cfg_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) report_fail("cfg_ready_timeout");
    @(negedge clk);
    acc = cyc;
  endtask

  // Loads one 16-bit word and queues its commit expectations; returns the last-accept cycle.
  task automatic send_word(input logic [15:0] w, input bit hold, input int tag, output int last_acc);
    int acc;
    logic [3:0] oe_exp;
    acc = 0;
    for (int k = 0; k < TOTAL; k++) send_bit(w[k], acc);
    for (int p = 0; p < NUM_PADS; p++) oe_exp[p] = w[4*p+3];
    last_acc = acc;
    expect_at(acc, S_RDY, 4'd0, tag);
    expect_at(acc + 1, S_RDY, 4'd1, tag);
    expect_at(acc + 1, S_OE, oe_exp, tag);
    done_q.push_back(acc + 1);
    done_expected++;
    if (!hold) begin
      cfg_if.cfg_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  logic [11:0] pat = 12'b0111_0100_1101;

  initial begin
    int a1, a2, dummy, n;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_bit   = 1'b0;
    fork
      begin
        #1000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (2) @(negedge clk);
    rst = 1'b0;
    expect_at(cyc, S_OE, 4'b0000, 1);
    expect_at(cyc, S_RDY, 4'd1, 1);
    expect_at(cyc, S_A2F, 4'b0000, 1);
    expect_at(cyc, S_SC, 4'd0, 1);
    @(negedge clk);

    send_word(16'h0000, 0, 2, dummy);
    pad_a2f = 4'b1010;
    f2a_i   = 4'b0110;
    expect_at(cyc, S_A2F, 4'b1010, 2);
    expect_at(cyc, S_F2A, 4'b0110, 2);
    @(negedge clk);

    send_word(16'h3333, 0, 3, dummy);
    n = cyc;
    pad_a2f = 4'b0101;
    expect_at(n,     S_A2F, 4'b1010, 3);
    expect_at(n + 1, S_A2F, 4'b1010, 3);
    expect_at(n + 2, S_A2F, 4'b0101, 3);
    repeat (2) @(negedge clk);

    send_word(16'h1111, 0, 4, dummy);
    n = cyc;
    pad_a2f = 4'b1100;
    expect_at(n,     S_A2F, 4'b0101, 4);
    expect_at(n + 1, S_A2F, 4'b1100, 4);
    @(negedge clk);

    send_word(16'hCCCC, 0, 5, dummy);
    n = cyc;
    f2a_i = 4'b1011;
    expect_at(n,     S_F2A, 4'b0110, 5);
    expect_at(n + 1, S_F2A, 4'b1011, 5);
    expect_at(n,     S_A2F, 4'b1100, 5);
    @(negedge clk);

    for (int k = 0; k < 4; k++) send_bit(1'b1, dummy);
    cfg_if.cfg_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      expect_at(cyc, S_RDY, 4'd1, 6);
      @(negedge clk);
    end
    for (int k = 4; k < 8; k++) send_bit(1'b1, dummy);
    cfg_if.cfg_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_at(cyc, S_OE, 4'b0000, 6);
    expect_at(cyc, S_A2F, 4'b1100, 6);
    expect_at(cyc, S_F2A, 4'b1011, 6);
    expect_at(cyc, S_SC, 4'd0, 6);
    expect_at(cyc, S_RDY, 4'd1, 6);
    @(negedge clk);
    send_word(16'h0008, 0, 7, dummy);
    @(negedge clk);

    fork
      begin
        scan_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
          sc_in = pat[i % 12];
          if (i < 12) expect_at(cyc + 12, S_SC, {3'b000, pat[i]}, 8);
          @(negedge clk);
        end
        scan_en = 1'b0;
        sc_in   = 1'b0;
      end
      begin
        send_word(16'h8000, 0, 8, dummy);
      end
    join
    @(negedge clk);

    send_word(16'h000F, 1, 9, a1);
    send_word(16'hF000, 0, 9, a2);
    check("b2b_last_accept_spacing", a2 - a1, 17);
    repeat (3) @(negedge clk);

    check("exp_queue_drained", exp_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);
    check("cfg_done_count", done_seen, done_expected);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
